// File: rtl/div_reconstruct.sv
// Sequential shift-add multiply-accumulator: n_o = q_i*d_i + r_i, one quotient bit per enabled cycle.
// Shares the divider's act_i/en_i/val_o handshake and its PRECISION+1 latency.
module div_reconstruct #(
  parameter int WIDTH     = 48,
  parameter int PRECISION = 47
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           en_i,
  input  logic                           act_i,
  input  logic [PRECISION:0]             q_i,
  input  logic [WIDTH-1:0]               d_i,
  input  logic [WIDTH-1:0]               r_i,
  output logic [WIDTH+PRECISION:0]       n_o,
  output logic                           val_o,
  output logic                           busy_o
);

  localparam int QW = PRECISION + 1;
  localparam int NW = WIDTH + PRECISION + 1;
  localparam int CW = $clog2(PRECISION + 2);

  logic [QW-1:0] r_q;
  logic [NW-1:0] r_dsh;
  logic [NW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [NW-1:0] r_n;
  logic          r_val;
  logic          r_busy;

  logic [NW-1:0] w_acc_next;
  logic          w_last;

  // LSB-first schedule: the accumulator starts at r, so r already sits at weight 1
  // and each step adds d shifted to the weight of the current quotient bit.
  assign w_acc_next = r_acc + (r_q[0] ? r_dsh : '0);
  assign w_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_q    <= '0;
      r_dsh  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_n    <= '0;
      r_val  <= 1'b0;
      r_busy <= 1'b0;
    end else if (en_i) begin
      r_val <= 1'b0;
      if (!r_busy && act_i) begin
        r_q    <= q_i;
        r_dsh  <= NW'(d_i);
        r_acc  <= NW'(r_i);
        r_cnt  <= CW'(QW);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= w_acc_next;
        r_dsh <= r_dsh << 1;
        r_q   <= r_q >> 1;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_n    <= w_acc_next;
          r_val  <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign n_o    = r_n;
  assign val_o  = r_val;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_div_reconstruct.sv
// Directed and random checks of div_reconstruct at WIDTH=8/PRECISION=7 and at the defaults.
module tb_div_reconstruct;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en_s, act_s;
  logic [7:0]  q_s, d_s, r_s;
  logic [15:0] n_s;
  logic        val_s, busy_s;

  logic        en_b, act_b;
  logic [47:0] q_b, d_b, r_b;
  logic [95:0] n_b;
  logic        val_b, busy_b;

  int checks   = 0;
  int failures = 0;

  div_reconstruct #(.WIDTH(8), .PRECISION(7)) u_small (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_s), .act_i(act_s),
    .q_i(q_s), .d_i(d_s), .r_i(r_s),
    .n_o(n_s), .val_o(val_s), .busy_o(busy_s)
  );

  div_reconstruct u_big (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .act_i(act_b),
    .q_i(q_b), .d_i(d_b), .r_i(r_b),
    .n_o(n_b), .val_o(val_b), .busy_o(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one small operation; reports edges from accept to val_o, the result and val_o width.
  task automatic small_run(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                           output int lat, output logic [15:0] n, output bit one);
    q_s = q; d_s = d; r_s = r; act_s = 1'b1;
    tick();
    act_s = 1'b0; q_s = ~q; d_s = ~d; r_s = ~r;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (val_s) break;
    end
    if (!val_s) lat = -1;
    n = n_s;
    tick();
    one = !val_s;
  endtask

  task automatic big_run(input logic [47:0] q, input logic [47:0] d, input logic [47:0] r,
                         output int lat, output logic [95:0] n, output bit one);
    q_b = q; d_b = d; r_b = r; act_b = 1'b1;
    tick();
    act_b = 1'b0; q_b = ~q; d_b = ~d; r_b = ~r;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (val_b) break;
    end
    if (!val_b) lat = -1;
    n = n_b;
    tick();
    one = !val_b;
  endtask

  task automatic test_reset();
    en_s = 1'b1; act_s = 1'b0; q_s = '0; d_s = '0; r_s = '0;
    en_b = 1'b1; act_b = 1'b0; q_b = '0; d_b = '0; r_b = '0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (n_s !== 16'h0 || val_s !== 1'b0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_small: got n=%h val=%b busy=%b expected n=0000 val=0 busy=0", n_s, val_s, busy_s);
    end
    checks++;
    if (n_b !== 96'h0 || val_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_big: got n=%h val=%b busy=%b expected 0/0/0", n_b, val_b, busy_b);
    end
    #2 rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_small_basic();
    q_s = 8'hFF; d_s = 8'hFF; r_s = 8'hFE; act_s = 1'b1;
    tick();
    act_s = 1'b0; q_s = 8'h00; d_s = 8'h00; r_s = 8'h00;
    checks++;
    if (busy_s !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_after_accept: got %b expected 1", busy_s);
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if (busy_s !== 1'b1 || val_s !== 1'b0) begin
        failures++;
        $display("FAIL basic_busy_cycle%0d: got busy=%b val=%b expected busy=1 val=0", k, busy_s, val_s);
      end
    end
    tick();
    checks++;
    if (val_s !== 1'b1 || n_s !== 16'hFEFF || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got val=%b n=%h busy=%b expected val=1 n=feff busy=0", val_s, n_s, busy_s);
    end
    tick();
    checks++;
    if (val_s !== 1'b0 || n_s !== 16'hFEFF) begin
      failures++;
      $display("FAIL basic_hold: got val=%b n=%h expected val=0 n=feff", val_s, n_s);
    end
    $display("test_small_basic: q=ff d=ff r=fe n=%h", n_s);
  endtask

  task automatic test_defaults();
    int lat; logic [95:0] n; bit one;
    big_run(48'h0, 48'hFFFF_FFFF_FFFF, 48'd5, lat, n, one);
    checks++;
    if (lat != 48 || n !== 96'd5 || !one) begin
      failures++;
      $display("FAIL defaults_q0: got lat=%0d n=%h one=%b expected lat=48 n=5 one=1", lat, n, one);
    end
    $display("test_defaults: q=0 r=5 n=%h lat=%0d", n, lat);
    big_run(48'h1, 48'd3, 48'd0, lat, n, one);
    checks++;
    if (lat != 48 || n !== 96'd3 || !one) begin
      failures++;
      $display("FAIL defaults_q1: got lat=%0d n=%h one=%b expected lat=48 n=3 one=1", lat, n, one);
    end
    $display("test_defaults: q=1 d=3 n=%h lat=%0d", n, lat);
    big_run(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, lat, n, one);
    checks++;
    if (lat != 48 || n !== 96'hFFFF_FFFF_FFFF_0000_0000_0000 || !one) begin
      failures++;
      $display("FAIL defaults_max: got lat=%0d n=%h one=%b expected lat=48 n=ffffffffffff000000000000", lat, n, one);
    end
    $display("test_defaults: max operands n=%h", n);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vq [3] = '{8'h03, 8'h80, 8'h55};
    logic [7:0]  vd [3] = '{8'h05, 8'h02, 8'hAA};
    logic [7:0]  vr [3] = '{8'h01, 8'hFF, 8'h10};
    logic [15:0] ve [3] = '{16'h0010, 16'h01FF, 16'h3882};
    int lat;
    act_s = 1'b1;
    q_s = vq[0]; d_s = vd[0]; r_s = vr[0];
    tick();
    for (int j = 0; j < 3; j++) begin
      q_s = 8'hFF; d_s = 8'hFF; r_s = 8'hFF;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        lat++;
        if (val_s) break;
      end
      checks++;
      if (!val_s || lat != 8 || n_s !== ve[j]) begin
        failures++;
        $display("FAIL b2b_result%0d: got val=%b lat=%0d n=%h expected val=1 lat=8 n=%h", j, val_s, lat, n_s, ve[j]);
      end
      $display("test_back_to_back: result %0d n=%h lat=%0d", j, n_s, lat);
      if (j < 2) begin
        q_s = vq[j+1]; d_s = vd[j+1]; r_s = vr[j+1];
      end else begin
        act_s = 1'b0;
      end
      tick();
      checks++;
      if (val_s !== 1'b0 || busy_s !== (j < 2)) begin
        failures++;
        $display("FAIL b2b_accept%0d: got val=%b busy=%b expected val=0 busy=%b", j, val_s, busy_s, j < 2);
      end
    end
    act_s = 1'b0;
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] held;
    q_s = 8'h12; d_s = 8'h34; r_s = 8'h56; act_s = 1'b1;
    tick();
    act_s = 1'b0; q_s = 8'h00; d_s = 8'h00; r_s = 8'h00;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      en_s = (k >= 4 && k <= 13) ? 1'b0 : 1'b1;
      tick();
      lat++;
      if (val_s) break;
    end
    en_s = 1'b1;
    checks++;
    if (!val_s || lat != 18 || n_s !== 16'h03FE) begin
      failures++;
      $display("FAIL stall_latency: got val=%b lat=%0d n=%h expected val=1 lat=18 n=03fe", val_s, lat, n_s);
    end
    $display("test_stall: n=%h lat=%0d", n_s, lat);
    held = n_s;
    en_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (val_s !== 1'b1 || n_s !== held) begin
        failures++;
        $display("FAIL stall_val_hold%0d: got val=%b n=%h expected val=1 n=%h", k, val_s, n_s, held);
      end
    end
    en_s = 1'b1;
    tick();
    checks++;
    if (val_s !== 1'b0) begin
      failures++;
      $display("FAIL stall_val_drop: got val=%b expected 0", val_s);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic [15:0] n; bit one; bit seen;
    q_s = 8'hFF; d_s = 8'hFF; r_s = 8'hFE; act_s = 1'b1;
    tick();
    act_s = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (n_s !== 16'h0 || busy_s !== 1'b0 || val_s !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got n=%h busy=%b val=%b expected 0000/0/0", n_s, busy_s, val_s);
    end
    tick(); tick();
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (val_s || busy_s) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_abort: got activity=1 expected activity=0");
    end
    small_run(8'h02, 8'h07, 8'h03, lat, n, one);
    checks++;
    if (lat != 8 || n !== 16'h0011 || !one) begin
      failures++;
      $display("FAIL after_reset: got lat=%0d n=%h one=%b expected lat=8 n=0011 one=1", lat, n, one);
    end
    $display("test_async_reset: post-reset n=%h lat=%0d", n, lat);
  endtask

  task automatic test_random();
    int lat; logic [95:0] n; bit one;
    logic [63:0] t;
    logic [47:0] q, d, r;
    logic [95:0] exp;
    for (int i = 0; i < 200; i++) begin
      t = {$urandom, $urandom}; q = t[47:0];
      t = {$urandom, $urandom}; d = t[47:0];
      t = {$urandom, $urandom}; r = t[47:0];
      exp = 96'(q) * 96'(d) + 96'(r);
      big_run(q, d, r, lat, n, one);
      checks++;
      if (lat != 48 || n !== exp || !one) begin
        failures++;
        $display("FAIL random%0d: got lat=%0d n=%h one=%b expected lat=48 n=%h one=1", i, lat, n, one, exp);
      end
      $display("test_random %0d: q=%h d=%h r=%h n=%h", i, q, d, r, n);
    end
  endtask

  initial begin
    test_reset();
    test_small_basic();
    test_defaults();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
